// File: rtl/sudoku_uart_pkg.sv
// Constants and state encoding shared by the sudoku UART event protocol (receive and transmit sides).
package sudoku_uart_pkg;

    localparam logic [7:0] EV_FULL_MAP    = 8'hAC;
    localparam logic [7:0] EV_CELL_UPDATE = 8'hA1;
    localparam logic [7:0] EV_GAME_OVER   = 8'hA5;

    localparam int unsigned MAP_BITS               = 324;
    localparam int unsigned FULL_MAP_PAYLOAD_BYTES = 41;
    localparam int unsigned FULL_MAP_PAYLOAD_BITS  = 8 * FULL_MAP_PAYLOAD_BYTES;
    localparam int unsigned PAD_BITS               = FULL_MAP_PAYLOAD_BITS - MAP_BITS;
    localparam int unsigned BYTE_CNT_W             = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RECEBENDO = 2'd1,
        ST_VALIDANDO = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter for the full-map receiver; present only when RX_TIMEOUT_EN is defined.
`ifdef RX_TIMEOUT_EN
module rx_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Saturates at LIMIT so a held enable can never wrap around.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_c = enable && (count_q == LIMIT);

endmodule
`endif

// File: rtl/full_map_receive_controller.sv
// Receives an EV_FULL_MAP frame byte by byte and publishes the 324-bit map atomically.
// Optional inter-byte timeout is enabled with the RX_TIMEOUT_EN macro.
module full_map_receive_controller
    import sudoku_uart_pkg::*;
`ifdef RX_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
)
`endif
(
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          dado_recebido,
    input  logic                dado_valido,
    output logic [MAP_BITS-1:0] full_map_output,
    output logic                recepcao_concluida,
    output logic                recebendo,
    output logic                erro_quadro
);

    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(FULL_MAP_PAYLOAD_BYTES - 1);

    rx_state_e                        state_q, state_d;
    logic [BYTE_CNT_W-1:0]            cnt_q, cnt_d;
    logic [FULL_MAP_PAYLOAD_BITS-1:0] shadow_q, shadow_d;
    logic [MAP_BITS-1:0]              map_d;
    logic                             done_d, err_d, busy_d;
    logic                             timeout_c;

`ifdef RX_TIMEOUT_EN
    rx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx_timeout_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (dado_valido),
        .enable   (state_q == ST_RECEBENDO),
        .expired_c(timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State, byte collector and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            cnt_q              <= '0;
            shadow_q           <= '0;
            full_map_output    <= '0;
            recepcao_concluida <= 1'b0;
            erro_quadro        <= 1'b0;
            recebendo          <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            shadow_q           <= shadow_d;
            full_map_output    <= map_d;
            recepcao_concluida <= done_d;
            erro_quadro        <= err_d;
            recebendo          <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        map_d    = full_map_output;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dado_valido && (dado_recebido == EV_FULL_MAP)) begin
                    state_d = ST_RECEBENDO;
                    cnt_d   = '0;
                end
            end
            ST_RECEBENDO: begin
                if (timeout_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (dado_valido) begin
                    // Header value inside a frame is plain payload: no resync.
                    shadow_d[{cnt_q, 3'b000} +: 8] = dado_recebido;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_VALIDANDO;
                    end else begin
                        cnt_d = cnt_q + BYTE_CNT_W'(1);
                    end
                end
            end
            ST_VALIDANDO: begin
                if (shadow_q[FULL_MAP_PAYLOAD_BITS-1 -: PAD_BITS] == '0) begin
                    map_d  = shadow_q[MAP_BITS-1:0];
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule
